multichannel_echo: RTL and testbench

Parameterised multichannel echo/delay processor between the I2S receiver and transmitter in the audio path. Generalises the fixed stereo echo in four ways: N channels, a runtime-programmable delay length, a feedback gain and a wet gain. It also clears its delay memory after reset. It runs on a single system clock and exchanges whole sample frames through a valid/ready handshake.

---
 rtl/multichannel_echo.sv | 205 ++++++++++++++++++++
 tb/tb_multichannel_echo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_echo.sv
// Multichannel echo/delay between I2S receiver and transmitter.
// One shared RAM delay line; channels are processed serially per frame.
module multichannel_echo #(
    parameter int unsigned BITSIZE    = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH_LOG2 = 13,
    parameter int unsigned GAINBITS   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DEPTH_LOG2-1:0]        delay,
    input  logic [GAINBITS-1:0]          feedback,
    input  logic [GAINBITS-1:0]          wet,
    input  logic                         in_valid,
    input  logic [CHANNELS*BITSIZE-1:0]  in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [CHANNELS*BITSIZE-1:0]  out_data
);

    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW    = CH_W + DEPTH_LOG2;
    localparam int unsigned WORDS = CHANNELS << DEPTH_LOG2;
    localparam int unsigned PW    = BITSIZE + GAINBITS + 1;

    localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CHANNELS - 1);

    localparam logic signed [PW-1:0] SAT_MAX = {{(GAINBITS + 2){1'b0}}, {(BITSIZE - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(GAINBITS + 2){1'b1}}, {(BITSIZE - 1){1'b0}}};

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CALC  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // x + floor(d * g / 2^GAINBITS), saturated to the sample range.
    function automatic logic [BITSIZE-1:0] mix(input logic [BITSIZE-1:0]  x,
                                               input logic [BITSIZE-1:0]  d,
                                               input logic [GAINBITS-1:0] g);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sum;
        prod = $signed({{(GAINBITS + 1){d[BITSIZE-1]}}, d}) * $signed({{(BITSIZE + 1){1'b0}}, g});
        sum  = $signed({{(GAINBITS + 1){x[BITSIZE-1]}}, x}) + (prod >>> GAINBITS);
        if (sum > SAT_MAX) begin
            mix = SAT_MAX[BITSIZE-1:0];
        end else if (sum < SAT_MIN) begin
            mix = SAT_MIN[BITSIZE-1:0];
        end else begin
            mix = sum[BITSIZE-1:0];
        end
    endfunction

    logic [2:0]                    state_q, state_d;
    logic [AW-1:0]                 clr_addr_q, clr_addr_d;
    logic [DEPTH_LOG2-1:0]         wptr_q, wptr_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [CHANNELS*BITSIZE-1:0]   in_frame_q, in_frame_d;
    logic [DEPTH_LOG2-1:0]         delay_q, delay_d;
    logic [GAINBITS-1:0]           fb_q, fb_d;
    logic [GAINBITS-1:0]           wet_q, wet_d;
    logic                          en_q, en_d;
    logic [CHANNELS*BITSIZE-1:0]   out_data_q, out_data_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;

    logic [BITSIZE-1:0]            mem [WORDS];
    logic [BITSIZE-1:0]            rdata_q;
    logic                          ram_we;
    logic [AW-1:0]                 ram_addr;
    logic [BITSIZE-1:0]            ram_wdata;

    logic [DEPTH_LOG2-1:0]         delay_eff;
    logic [DEPTH_LOG2-1:0]         rptr;
    logic [BITSIZE-1:0]            x_cur;
    logic [BITSIZE-1:0]            y_cur;
    logic [BITSIZE-1:0]            w_cur;

    assign delay_eff = (delay_q == '0) ? DEPTH_LOG2'(1) : delay_q;
    assign rptr      = wptr_q - delay_eff;

    always_comb begin
        x_cur = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (ch_q == CH_W'(k)) begin
                x_cur = in_frame_q[k*BITSIZE +: BITSIZE];
            end
        end
        y_cur = en_q ? mix(x_cur, rdata_q, wet_q) : x_cur;
        w_cur = en_q ? mix(x_cur, rdata_q, fb_q) : x_cur;
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wptr_d     = wptr_q;
        ch_d       = ch_q;
        in_frame_d = in_frame_q;
        delay_d    = delay_q;
        fb_d       = fb_q;
        wet_d      = wet_q;
        en_d       = en_q;
        out_data_d = out_data_q;
        ram_we     = 1'b0;
        ram_addr   = {ch_q, rptr};
        ram_wdata  = '0;

        case (state_q)
            S_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    in_frame_d = in_data;
                    delay_d    = delay;
                    fb_d       = feedback;
                    wet_d      = wet;
                    en_d       = enable;
                    ch_d       = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_CALC;
            S_CALC: begin
                ram_we    = 1'b1;
                ram_addr  = {ch_q, wptr_q};
                ram_wdata = w_cur;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    if (ch_q == CH_W'(k)) begin
                        out_data_d[k*BITSIZE +: BITSIZE] = y_cur;
                    end
                end
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                wptr_d  = wptr_q + DEPTH_LOG2'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_CLEAR;
        endcase

        // Handshake outputs are registered from the next state.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            wptr_q      <= '0;
            ch_q        <= '0;
            in_frame_q  <= '0;
            delay_q     <= '0;
            fb_q        <= '0;
            wet_q       <= '0;
            en_q        <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            wptr_q      <= wptr_d;
            ch_q        <= ch_d;
            in_frame_q  <= in_frame_d;
            delay_q     <= delay_d;
            fb_q        <= fb_d;
            wet_q       <= wet_d;
            en_q        <= en_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Single-port RAM; a reset landing on a CALC cycle suppresses that write.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[ram_addr] <= ram_wdata;
        end else begin
            rdata_q <= mem[ram_addr];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_multichannel_echo.sv
// Scoreboard bench for multichannel_echo (2 channels, 16-deep line, 8-bit gains).
module tb_multichannel_echo;

    localparam int B  = 16;
    localparam int C  = 2;
    localparam int D  = 4;
    localparam int G  = 8;
    localparam int LEN = 1 << D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [D-1:0]  delay = '0;
    logic [G-1:0]  feedback = '0;
    logic [G-1:0]  wet = '0;
    logic          in_valid = 1'b0;
    logic [C*B-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [C*B-1:0] out_data;

    multichannel_echo #(
        .BITSIZE(B), .CHANNELS(C), .DEPTH_LOG2(D), .GAINBITS(G)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .delay(delay),
        .feedback(feedback), .wet(wet), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C*B-1:0] data;
        int             acc;
    } exp_t;

    exp_t           exp_q[$];
    logic [C*B-1:0] obs[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;

    // Reference: the delay line as an array of past written values per channel.
    int line_m[C][LEN];
    int wptr_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [C*B-1:0] act, input logic [C*B-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < C; c++)
            for (int i = 0; i < LEN; i++) line_m[c][i] = 0;
        wptr_m = 0;
    endfunction

    function automatic logic [C*B-1:0] model_frame(input logic [C*B-1:0] data, input logic en,
                                                   input int dl, input int fb, input int wt);
        logic [C*B-1:0]    res;
        logic signed [B-1:0] s;
        int x, d, y, w, back;
        back = (dl == 0) ? 1 : dl;
        for (int c = 0; c < C; c++) begin
            s = data[c*B +: B];
            x = s;
            d = line_m[c][(wptr_m - back + LEN) % LEN];
            if (en) begin
                y = sat(x + ((d * wt) >>> G));
                w = sat(x + ((d * fb) >>> G));
            end else begin
                y = x;
                w = x;
            end
            line_m[c][wptr_m] = w;
            res[c*B +: B] = B'(y);
        end
        wptr_m = (wptr_m + 1) % LEN;
        return res;
    endfunction

    // Monitor: pop and compare on every output pulse.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("latency", C*B'(cyc - e.acc), C*B'(7));
            end
            obs.push_back(out_data);
        end
    end

    task automatic send(input logic [C*B-1:0] data, input logic en, input int dl,
                        input int fb, input int wt, input int garbage);
        bit   done;
        exp_t e;
        done     = 0;
        in_data  = data;
        enable   = en;
        delay    = D'(dl);
        feedback = G'(fb);
        wet      = G'(wt);
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done   = 1;
                e.data = model_frame(data, en, dl, fb, wt);
                e.acc  = cyc;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
        // Busy period: scrambled controls and offered frames must all be ignored.
        for (int g = 0; g < garbage; g++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            enable   = 1'($urandom);
            delay    = D'($urandom);
            feedback = G'($urandom);
            wet      = G'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) check("drain_timeout", C*B'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic do_reset(input bit timed);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        obs.delete();
        model_reset();
        if (timed) begin
            for (int c = 1; c <= 33; c++) begin
                check($sformatf("clear_in_ready_c%0d", c), C*B'(in_ready), C*B'(c == 33));
                check("clear_out_valid", C*B'(out_valid), 0);
                check("clear_out_data", out_data, 0);
                if (c != 33) begin
                    @(posedge clk);
                    #1;
                end
            end
        end else begin
            for (int t = 0; t < 100 && !in_ready; t++) begin
                @(posedge clk);
                #1;
            end
            if (!in_ready) check("reset_ready_timeout", 0, 1);
        end
    endtask

    initial begin
        logic [B-1:0] v;

        // Reset and CLEAR timing; single echo tap.
        do_reset(1);
        send({16'd0, 16'd16000}, 1, 3, 0, 128, 0);
        repeat (5) send('0, 1, 3, 0, 128, 0);
        drain();
        check("t1_f0_ch0", C*B'(obs[0][15:0]), C*B'(16'd16000));
        check("t1_f3_ch0", C*B'(obs[3][15:0]), C*B'(16'd8000));
        check("t1_f3_ch1", C*B'(obs[3][31:16]), 0);

        // Decaying feedback on ch1.
        do_reset(0);
        send({16'd16000, 16'd0}, 1, 2, 128, 128, 0);
        repeat (6) send('0, 1, 2, 128, 128, 0);
        drain();
        check("t2_f2_ch1", C*B'(obs[2][31:16]), C*B'(16'd8000));
        check("t2_f4_ch1", C*B'(obs[4][31:16]), C*B'(16'd4000));
        check("t2_f6_ch1", C*B'(obs[6][31:16]), C*B'(16'd2000));

        // Saturation both directions.
        do_reset(0);
        v = 16'd30000;
        send({16'd0, v}, 1, 1, 0, 255, 0);
        send({16'd0, v}, 1, 1, 0, 255, 0);
        drain();
        check("t3_sat_pos", C*B'(obs[1][15:0]), C*B'(16'h7fff));
        do_reset(0);
        v = 16'(-30000);
        send({16'd0, v}, 1, 1, 0, 255, 0);
        send({16'd0, v}, 1, 1, 0, 255, 0);
        drain();
        check("t3_sat_neg", C*B'(obs[1][15:0]), C*B'(16'h8000));

        // Bypass with busy-time junk on the input.
        do_reset(0);
        repeat (6) send({$urandom, $urandom}, 0, 2, $urandom_range(255), $urandom_range(255), 5);
        drain();

        // Random mixes, including delay 0 and 15, and wraparound.
        repeat (40) send({$urandom, $urandom}, 1'($urandom_range(3) != 0),
                         $urandom_range(LEN - 1), $urandom_range(255), $urandom_range(255),
                         $urandom_range(5));
        send('0, 1, 0, 200, 200, 0);
        send('0, 1, LEN - 1, 200, 200, 0);
        drain();

        // Reset during CALC of ch1, after loading the line with loud data.
        repeat (8) send({$urandom, $urandom}, 1, 3, 255, 255, 0);
        drain();
        send({16'd12345, 16'd23456}, 1, 3, 200, 200, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", C*B'(in_ready), 0);
        check("abort_out_valid", C*B'(out_valid), 0);
        check("abort_out_data", out_data, 0);
        do_reset(1);
        send({16'd10000, 16'd10000}, 1, 3, 128, 128, 0);
        repeat (6) send('0, 1, 3, 128, 128, 0);
        drain();
        check("post_abort_f2", obs[2], 0);
        check("post_abort_f3", obs[3], {16'd5000, 16'd5000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
